aes_block_loader: RTL and testbench

//  Upstream feeder for the combinational AES-128 encrypt core. Packs a narrow word stream
//  (valid/ready) into 128-bit plaintext blocks and 128-bit cipher keys. Presents each

---
 rtl/aes_block_loader.sv | 161 ++++++++++++++++
 tb/tb_aes_block_loader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_block_loader.sv
// Packs a WORD_W valid/ready stream into 128-bit AES plaintext blocks and keys,
// presenting each block with its bound key on a registered valid/ready output.
// Ports: clk, rst (sync, active-high), flush, s_valid/s_ready/s_data/s_key in,
//   m_valid/m_ready/m_block/m_key out, key_valid, err_nokey (1-cycle pulse).
// Option: AES_LOADER_BYTESWAP_EN byte-reverses every input word before packing.
module aes_block_loader #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_key,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [127:0]      m_block,
  output logic [127:0]      m_key,
  output logic              key_valid,
  output logic              err_nokey
);

  localparam int WORDS = 128 / WORD_W;
  localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  logic [WORD_W-1:0] word_w;

`ifdef AES_LOADER_BYTESWAP_EN
  always_comb begin
    word_w = '0;
    for (int b = 0; b < WORD_W / 8; b++) begin
      word_w[8*b +: 8] = s_data[WORD_W-8-8*b +: 8];
    end
  end
`else
  assign word_w = s_data;
`endif

  logic [CW-1:0] data_cnt_q, data_cnt_d;
  logic [CW-1:0] key_cnt_q, key_cnt_d;
  logic [127:0]  blk_asm_q, blk_asm_d;
  logic [127:0]  key_asm_q, key_asm_d;
  logic [127:0]  key_act_q, key_act_d;
  logic          key_valid_q, key_valid_d;
  logic          m_valid_q, m_valid_d;
  logic [127:0]  m_block_q, m_block_d;
  logic [127:0]  m_key_q, m_key_d;
  logic          err_q, err_d;

  logic [127:0]  blk_ins;
  logic [127:0]  key_ins;
  logic          data_last;
  logic          key_last;
  logic          rdy;
  logic          acc;

  always_comb begin
    data_last = (data_cnt_q == LAST);
    key_last  = (key_cnt_q == LAST);

    // Assembly register with the incoming word dropped into its slice;
    // on a final word this is the complete group.
    blk_ins = blk_asm_q;
    key_ins = key_asm_q;
    for (int i = 0; i < WORDS; i++) begin
      if (data_cnt_q == CW'(i)) blk_ins[127-i*WORD_W -: WORD_W] = word_w;
      if (key_cnt_q == CW'(i))  key_ins[127-i*WORD_W -: WORD_W] = word_w;
    end

    // Stall everything (keys too) while a commit would overrun a held block.
    rdy = !(rst | flush | (data_last & m_valid_q & !m_ready));
    acc = s_valid & rdy;

    data_cnt_d  = data_cnt_q;
    key_cnt_d   = key_cnt_q;
    blk_asm_d   = blk_asm_q;
    key_asm_d   = key_asm_q;
    key_act_d   = key_act_q;
    key_valid_d = key_valid_q;
    m_valid_d   = m_valid_q;
    m_block_d   = m_block_q;
    m_key_d     = m_key_q;
    err_d       = 1'b0;

    if (m_ready) m_valid_d = 1'b0;

    unique case (1'b1)
      flush: begin
        data_cnt_d = '0;
        key_cnt_d  = '0;
        blk_asm_d  = '0;
        key_asm_d  = '0;
      end
      acc & s_key: begin
        if (key_last) begin
          key_act_d   = key_ins;
          key_valid_d = 1'b1;
          key_asm_d   = '0;
          key_cnt_d   = '0;
        end else begin
          key_asm_d = key_ins;
          key_cnt_d = key_cnt_q + CW'(1);
        end
      end
      acc & !s_key: begin
        if (data_last) begin
          // Commit binds the key that was active before this edge.
          if (key_valid_q) begin
            m_valid_d = 1'b1;
            m_block_d = blk_ins;
            m_key_d   = key_act_q;
          end else begin
            err_d = 1'b1;
          end
          blk_asm_d  = '0;
          data_cnt_d = '0;
        end else begin
          blk_asm_d  = blk_ins;
          data_cnt_d = data_cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_cnt_q  <= '0;
      key_cnt_q   <= '0;
      blk_asm_q   <= '0;
      key_asm_q   <= '0;
      key_act_q   <= '0;
      key_valid_q <= 1'b0;
      m_valid_q   <= 1'b0;
      m_block_q   <= '0;
      m_key_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      data_cnt_q  <= data_cnt_d;
      key_cnt_q   <= key_cnt_d;
      blk_asm_q   <= blk_asm_d;
      key_asm_q   <= key_asm_d;
      key_act_q   <= key_act_d;
      key_valid_q <= key_valid_d;
      m_valid_q   <= m_valid_d;
      m_block_q   <= m_block_d;
      m_key_q     <= m_key_d;
      err_q       <= err_d;
    end
  end

  assign s_ready   = rdy;
  assign m_valid   = m_valid_q;
  assign m_block   = m_block_q;
  assign m_key     = m_key_q;
  assign key_valid = key_valid_q;
  assign err_nokey = err_q;

endmodule

// File: tb/tb_aes_block_loader.sv
// Scoreboard bench for aes_block_loader (WORD_W=32): directed FIPS-197 and
// corner sequences plus randomized traffic against a word-queue model.
module tb_aes_block_loader;

  localparam int W     = 32;
  localparam int WORDS = 128 / W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [W-1:0]  s_data = '0;
  logic          s_key = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [127:0]  m_block;
  logic [127:0]  m_key;
  logic          key_valid;
  logic          err_nokey;

  aes_block_loader #(.WORD_W(W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_key(s_key),
    .m_valid(m_valid), .m_ready(m_ready), .m_block(m_block), .m_key(m_key),
    .key_valid(key_valid), .err_nokey(err_nokey)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: pending words, active key, output occupancy.
  logic [W-1:0]   dq[$];
  logic [W-1:0]   kq[$];
  logic [127:0]   key_act = '0;
  bit             key_have = 0;
  bit             occ = 0;
  int             err_pend = 0;
  logic [255:0]   sb[$];

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] host(input logic [W-1:0] w);
    logic [W-1:0] r;
`ifdef AES_LOADER_BYTESWAP_EN
    for (int b = 0; b < W / 8; b++) r[8*b +: 8] = w[W-8-8*b +: 8];
`else
    r = w;
`endif
    return r;
  endfunction

  function automatic logic [127:0] pack(input logic [W-1:0] q[$]);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < WORDS; i++) r[127-i*W -: W] = q[i];
    return r;
  endfunction

  // Applies one accepted word; returns 1 when a block enters the output.
  function automatic bit model_word(input bit k, input logic [W-1:0] d);
    bit c;
    c = 0;
    if (k) begin
      kq.push_back(host(d));
      if (kq.size() == WORDS) begin
        key_act  = pack(kq);
        key_have = 1;
        kq.delete();
      end
    end else begin
      dq.push_back(host(d));
      if (dq.size() == WORDS) begin
        if (key_have) begin
          sb.push_back({pack(dq), key_act});
          c = 1;
        end else begin
          err_pend++;
        end
        dq.delete();
      end
    end
    return c;
  endfunction

  // One clock: drive at posedge+1, check and advance the model at negedge.
  task automatic cyc(input bit v, input bit k, input logic [W-1:0] d,
                     input bit fl, input bit mr, output bit took);
    bit exp_rdy;
    bit c;
    @(posedge clk);
    #1;
    s_valid = v; s_key = k; s_data = d; flush = fl; m_ready = mr;
    @(negedge clk);
    exp_rdy = !fl && !(dq.size() == WORDS - 1 && occ && !mr);
    chk("s_ready", s_ready, exp_rdy);
    chk("key_valid", key_valid, key_have);
    if (fl) begin
      dq.delete();
      kq.delete();
    end
    c = 0;
    took = v && exp_rdy;
    if (took) c = model_word(k, d);
    occ = (occ && !mr) || c;
  endtask

  task automatic idle(input int n);
    bit t;
    for (int i = 0; i < n; i++) cyc(0, 0, '0, 0, 1, t);
  endtask

  // Retries a word until accepted; forces m_ready after a few stalls.
  task automatic send(input bit k, input logic [W-1:0] d, input bit mr);
    bit t;
    t = 0;
    for (int n = 0; n < 40 && !t; n++) cyc(1, k, d, 0, (n > 3) ? 1'b1 : mr, t);
    if (!t) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout actual=stalled required=accepted");
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1; s_valid = 0; flush = 0; m_ready = 0;
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_block", m_block, 0);
    chk("rst_m_key", m_key, 0);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_err_nokey", err_nokey, 0);
    dq.delete(); kq.delete(); sb.delete();
    key_act = '0; key_have = 0; occ = 0; err_pend = 0;
  endtask

  // Monitor: every presented output must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL out_unexpected actual=%h required=none", m_block);
        end else begin
          chk("m_block", m_block, sb[0][255:128]);
          chk("m_key", m_key, sb[0][127:0]);
          if (m_ready) void'(sb.pop_front());
        end
      end
      if (err_nokey) begin
        n_checks++;
        if (err_pend == 0) begin
          n_fail++;
          $display("FAIL err_nokey actual=1 required=0");
        end else begin
          err_pend--;
        end
      end
    end
  end

  logic [W-1:0] fk[4] = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};
  logic [W-1:0] fp[4] = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};

  initial begin
    bit t;
    do_reset();

    // Plaintext with no key: dropped, error pulse, nothing presented.
    for (int i = 0; i < 4; i++) send(0, fp[i], 1);
    idle(3);
    chk("nokey_m_valid", m_valid, 0);
    chk("nokey_err_pend", err_pend, 0);

    // FIPS-197 C.1 key and plaintext.
    for (int i = 0; i < 4; i++) send(1, fk[i], 1);
    for (int i = 0; i < 4; i++) send(0, fp[i], 1);
    idle(3);

    // Two blocks under backpressure; second waits for m_ready.
    for (int i = 0; i < 8; i++) send(0, $urandom, 0);
    idle(3);

    // Key update interleaved with a block.
    send(0, $urandom, 1);
    for (int i = 0; i < 4; i++) send(1, $urandom, 1);
    for (int i = 0; i < 3; i++) send(0, $urandom, 1);
    for (int i = 0; i < 4; i++) send(0, $urandom, 1);
    idle(2);

    // Partial key discarded by flush, then all-ones key.
    send(1, 32'h12345678, 1);
    send(1, 32'h9abcdef0, 1);
    cyc(1, 1, 32'hdeadbeef, 1, 1, t);
    for (int i = 0; i < 4; i++) send(1, 32'hffffffff, 1);
    for (int i = 0; i < 4; i++) send(0, $urandom, 1);
    idle(3);
    chk("flush_key_all_ones", key_act, {128{1'b1}});

    // Byte-order probe and reset mid-block.
    send(0, 32'h33221100, 1);
    send(0, $urandom, 1);
    do_reset();
    for (int i = 0; i < 4; i++) send(1, $urandom, 1);
    for (int i = 0; i < 4; i++) send(0, $urandom, 1);
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3), $urandom,
          ($urandom_range(0, 99) < 3), ($urandom_range(0, 9) < 7), t);
    end

    idle(6);
    chk("sb_drained", sb.size(), 0);
    chk("err_drained", err_pend, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
